// File: rtl/geva_pipe_pkg.sv
// Shared types and defaults for GEVA pipeline stage registers.
package geva_pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        FULL  = 2'b10
    } skid_state_t;

    localparam int DEFAULT_WIDTH = 32;

endpackage

// File: rtl/pipe_skid_reg.sv
// Two-entry elastic pipeline register with registered in_ready.
// Optional synchronous squash input enabled by PIPE_SKID_FLUSH_EN.
//
// state | meaning
// EMPTY | no word buffered, out_valid=0, in_ready=1
// ONE   | main holds the oldest word, skid free
// FULL  | main holds the oldest word, skid holds the next one, in_ready=0
module pipe_skid_reg
    import geva_pipe_pkg::*;
#(
    parameter int N = DEFAULT_WIDTH
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
`ifdef PIPE_SKID_FLUSH_EN
    input  logic         flush,
`endif
    output logic [N-1:0] out_data
);

    skid_state_t  state;
    skid_state_t  next_state;
    logic [N-1:0] main_q;
    logic [N-1:0] skid_q;
    logic         load_main;
    logic         load_skid;
    logic         main_from_skid;

    always_comb begin
        next_state     = state;
        load_main      = 1'b0;
        load_skid      = 1'b0;
        main_from_skid = 1'b0;
        case (state)
            EMPTY: begin
                if (in_valid) begin
                    next_state = ONE;
                    load_main  = 1'b1;
                end
            end
            ONE: begin
                if (in_valid && out_ready) begin
                    load_main = 1'b1;
                end else if (in_valid) begin
                    next_state = FULL;
                    load_skid  = 1'b1;
                end else if (out_ready) begin
                    next_state = EMPTY;
                end
            end
            FULL: begin
                if (out_ready) begin
                    next_state     = ONE;
                    main_from_skid = 1'b1;
                end
            end
            default: next_state = EMPTY;
        endcase
`ifdef PIPE_SKID_FLUSH_EN
        // Squash wins over everything and leaves the data registers untouched.
        if (flush) begin
            next_state     = EMPTY;
            load_main      = 1'b0;
            load_skid      = 1'b0;
            main_from_skid = 1'b0;
        end
`endif
    end

    // Handshake flags are registered alongside the state so no combinational path leaves the block.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            state     <= next_state;
            out_valid <= (next_state != EMPTY);
            in_ready  <= (next_state != FULL);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_q <= '0;
        end else if (load_main) begin
            main_q <= in_data;
        end else if (main_from_skid) begin
            main_q <= skid_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skid_q <= '0;
        end else if (load_skid) begin
            skid_q <= in_data;
        end
    end

    assign out_data = main_q;

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Bench for pipe_skid_reg: directed scenarios then random traffic against a FIFO reference.
// Define PIPE_SKID_FLUSH_EN to also exercise the flush input.
module tb_pipe_skid_reg;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
`ifdef PIPE_SKID_FLUSH_EN
    logic        flush;
`endif

    int checks = 0;
    int errors = 0;

    // Reference: the buffer is a FIFO of at most two words; out_data is the last word presented.
    logic [31:0] q[$];
    logic [31:0] main_val;

    pipe_skid_reg #(.N(32)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
`ifdef PIPE_SKID_FLUSH_EN
        .flush    (flush),
`endif
        .out_data (out_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_model(input string tag);
        check_val({tag, ".in_ready"},  {31'd0, in_ready},  {31'd0, (q.size() < 2)});
        check_val({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, (q.size() > 0)});
        check_val({tag, ".out_data"},  out_data, main_val);
    endtask

    task automatic model_reset();
        q.delete();
        main_val = 32'd0;
    endtask

    task automatic model_edge(input logic iv, input logic [31:0] d, input logic ordy, input logic fl);
        logic pop;
        logic push;
        pop  = (q.size() > 0) && ordy;
        push = iv && (q.size() < 2);
        if (fl) begin
            q.delete();
        end else begin
            if (pop)  void'(q.pop_front());
            if (push) q.push_back(d);
            if (q.size() > 0) main_val = q[0];
        end
    endtask

    task automatic step(input logic iv, input logic [31:0] d, input logic ordy, input logic fl,
                        input string tag);
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
`ifdef PIPE_SKID_FLUSH_EN
        flush     = fl;
`endif
        @(posedge clk);
`ifdef PIPE_SKID_FLUSH_EN
        model_edge(iv, d, ordy, fl);
`else
        model_edge(iv, d, ordy, 1'b0);
`endif
        #1;
        check_model(tag);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'hDEAD_BEEF;
        out_ready = 1'b0;
`ifdef PIPE_SKID_FLUSH_EN
        flush     = 1'b0;
`endif
        model_reset();

        #12;
        check_val("reset.out_valid", {31'd0, out_valid}, 32'd0);
        check_val("reset.in_ready",  {31'd0, in_ready},  32'd1);
        check_val("reset.out_data",  out_data, 32'd0);
        rst_n = 1'b1;
        step(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, "first_accept");
        check_val("first_accept.data", out_data, 32'hDEAD_BEEF);

        for (int i = 1; i <= 4; i++) begin
            step(1'b1, i, 1'b1, 1'b0, "stream");
            check_val("stream.data", out_data, i);
        end
        step(1'b0, 32'd0, 1'b1, 1'b0, "drain");
        check_val("drain.hold_data", out_data, 32'd4);

        step(1'b1, 32'd11, 1'b0, 1'b0, "bp_push11");
        step(1'b1, 32'd22, 1'b0, 1'b0, "bp_push22");
        check_val("bp.in_ready_low", {31'd0, in_ready}, 32'd0);
        check_val("bp.head_held",    out_data, 32'd11);
        step(1'b1, 32'd33, 1'b0, 1'b0, "bp_offer33");
        check_val("bp.still_11", out_data, 32'd11);
        step(1'b1, 32'd33, 1'b1, 1'b0, "bp_out11");
        check_val("bp.out22", out_data, 32'd22);
        step(1'b1, 32'd33, 1'b1, 1'b0, "bp_accept33");
        check_val("bp.out33", out_data, 32'd33);
        step(1'b0, 32'd0, 1'b1, 1'b0, "bp_drain");

        step(1'b1, 32'd5, 1'b0, 1'b0, "ar_fill5");
        step(1'b1, 32'd6, 1'b0, 1'b0, "ar_fill6");
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_val("async_rst.out_valid", {31'd0, out_valid}, 32'd0);
        check_val("async_rst.in_ready",  {31'd0, in_ready},  32'd1);
        check_model("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 32'd77, 1'b0, 1'b0, "post_rst_accept");

`ifdef PIPE_SKID_FLUSH_EN
        step(1'b1, 32'd5, 1'b1, 1'b0, "fl_fill5");
        step(1'b1, 32'd6, 1'b0, 1'b0, "fl_fill6");
        step(1'b1, 32'd7, 1'b1, 1'b1, "flush");
        check_val("flush.out_valid", {31'd0, out_valid}, 32'd0);
        check_val("flush.in_ready",  {31'd0, in_ready},  32'd1);
        step(1'b0, 32'd0, 1'b1, 1'b0, "flush_after");
`endif

        for (int i = 0; i < 400; i++) begin
            logic fl;
            fl = 1'b0;
`ifdef PIPE_SKID_FLUSH_EN
            fl = ($urandom_range(0, 15) == 0);
`endif
            step($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 2) != 0, fl, "random");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
